// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned PC_AHEAD    = 8;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Branch target and link address adder, shared with decoder-side BL logic.
module branch_target_calc #(
  parameter int unsigned ADDR_W   = fetch_pkg::DEF_ADDR_W,
  parameter int unsigned PC_AHEAD = fetch_pkg::PC_AHEAD,
  parameter int unsigned PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_offset,
  output logic [ADDR_W-1:0] o_target,
  output logic [ADDR_W-1:0] o_link
);

  logic [ADDR_W-1:0] w_sum;

  // Target wraps modulo 2^ADDR_W and is forced word-aligned.
  always_comb begin
    w_sum    = i_pc + ADDR_W'(PC_AHEAD) + i_offset;
    o_target = {w_sum[ADDR_W-1:2], 2'b00};
    o_link   = i_pc + ADDR_W'(PC_STEP);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time,
// holds the returned word for the decoder and applies branch redirects.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = fetch_pkg::DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = fetch_pkg::DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
  parameter int unsigned       PC_AHEAD = fetch_pkg::PC_AHEAD
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  link_addr,
  input  logic               decode_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  b_offset
);

  import fetch_pkg::*;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_addr;
  logic               r_imem_req;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_instr_valid;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_link;

  branch_target_calc #(
    .ADDR_W   (ADDR_W),
    .PC_AHEAD (PC_AHEAD),
    .PC_STEP  (PC_STEP)
  ) u_btc (
    .i_pc     (r_instr_pc),
    .i_offset (b_offset),
    .o_target (w_target),
    .o_link   (w_link)
  );

  // Fetch FSM with registered request, address and instruction register.
  // The FETCH state is entered from reset with the request still low; that
  // single idle cycle raises the request, so acks are only honoured while
  // the registered request is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
            if (br_taken) begin
              r_pc       <= w_target;
              r_req_addr <= w_target;
            end
          end else if (imem_ack) begin
            if (br_taken) begin
              r_pc       <= w_target;
              r_req_addr <= w_target;
            end else begin
              r_instruction <= imem_rdata;
              r_instr_pc    <= r_req_addr;
              r_instr_valid <= 1'b1;
              r_pc          <= r_req_addr + ADDR_W'(PC_STEP);
              r_imem_req    <= 1'b0;
              r_state       <= HOLD;
            end
          end else if (br_taken) begin
            r_pc    <= w_target;
            r_state <= DROP;
          end
        end
        DROP: begin
          if (br_taken) begin
            r_pc <= w_target;
          end
          if (imem_ack) begin
            r_req_addr <= br_taken ? w_target : r_pc;
            r_state    <= FETCH;
          end
        end
        HOLD: begin
          if (br_taken) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_target;
            r_req_addr    <= w_target;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end else if (decode_ready) begin
            r_instr_valid <= 1'b0;
            r_req_addr    <= r_pc;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_req_addr;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign link_addr   = w_link;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory responder
// checks request addresses and a monitor checks each presented instruction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default reset PC, driven by the memory responder.
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] link_addr;
  logic        decode_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] b_offset = '0;

  // Instance 2: reset PC at the top of the address space, driven directly.
  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic [31:0] instr2;
  logic        valid2;
  logic [31:0] ipc2;
  logic [31:0] link2;
  logic        ready2 = 1'b0;
  logic        br2 = 1'b0;
  logic [31:0] off2 = '0;

  fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0000_0000),
    .PC_AHEAD (8)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .link_addr    (link_addr),
    .decode_ready (decode_ready),
    .br_taken     (br_taken),
    .b_offset     (b_offset)
  );

  fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'hFFFF_FFFC),
    .PC_AHEAD (8)
  ) u_dut_hi (
    .clk          (clk),
    .reset        (rst2),
    .imem_req     (req2),
    .imem_addr    (addr2),
    .imem_ack     (ack2),
    .imem_rdata   (rdata2),
    .instruction  (instr2),
    .instr_valid  (valid2),
    .instr_pc     (ipc2),
    .link_addr    (link2),
    .decode_ready (ready2),
    .br_taken     (br2),
    .b_offset     (off2)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_ipc[$];
  logic [31:0] q_iword[$];

  int lat = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1001;
    return a * 32'h9E37_79B9 + 32'h1;
  endfunction

  task automatic expect_fetch(input logic [31:0] a, input bit delivered);
    q_addr.push_back(a);
    if (delivered) begin
      q_ipc.push_back(a);
      q_iword.push_back(mem_word(a));
    end
  endtask

  // Memory responder and output monitor, evaluated on each falling edge.
  initial begin : responder
    bit          pending = 1'b0;
    bit          prev_valid = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending    = 1'b0;
        prev_valid = 1'b0;
        imem_ack   = 1'b0;
      end else begin
        if (instr_valid) check("req_low_in_hold", {31'b0, imem_req}, 32'd0);
        if (instr_valid && !prev_valid) begin
          check("sb_instr_avail", {31'b0, q_ipc.size() != 0}, 32'd1);
          if (q_ipc.size() != 0) begin
            check("instr_pc", instr_pc, q_ipc.pop_front());
            check("instruction", instruction, q_iword.pop_front());
          end
        end
        prev_valid = instr_valid;
        imem_ack = 1'b0;
        if (pending) begin
          check("addr_stable", imem_addr, paddr);
          check("req_held", {31'b0, imem_req}, 32'd1);
          cnt--;
          if (cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(paddr);
            pending    = 1'b0;
          end
        end else if (imem_req) begin
          check("sb_addr_avail", {31'b0, q_addr.size() != 0}, 32'd1);
          if (q_addr.size() != 0) check("fetch_addr", imem_addr, q_addr.pop_front());
          pending = 1'b1;
          cnt     = lat;
          paddr   = imem_addr;
        end
      end
    end
  end

  task automatic wait_valid_rise(input int budget);
    int n = 0;
    while (instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic pulse_br(input logic [31:0] off);
    br_taken = 1'b1;
    b_offset = off;
    @(negedge clk);
    br_taken = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_link", link_addr, 32'h4);

    // First fetch, then consume and refetch the next word
    lat = 1;
    expect_fetch(32'h0, 1'b1);
    reset = 1'b0;
    wait_valid_rise(20);
    check("first_link", link_addr, 32'h4);
    expect_fetch(32'h4, 1'b1);
    decode_ready = 1'b1;
    @(negedge clk);
    decode_ready = 1'b0;
    wait_valid_rise(20);

    // Decoder stall: outputs frozen, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_instr", instruction, mem_word(32'h4));
      check("stall_ipc", instr_pc, 32'h4);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end

    // Sequential stream, 3-cycle memory, decoder always ready
    reset = 1'b1;
    lat = 3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4), 1'b1);
    decode_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) wait_valid_rise(40);
    decode_ready = 1'b0;
    @(negedge clk);

    // Branch from HOLD at 0xC to 0x20
    lat = 1;
    check("br1_link", link_addr, 32'h10);
    expect_fetch(32'h20, 1'b1);
    pulse_br(32'h0000_000C);
    wait_valid_rise(20);

    // Branch from 0x20 with offset -8; decode_ready asserted alongside
    check("br2_link", link_addr, 32'h24);
    expect_fetch(32'h20, 1'b1);
    decode_ready = 1'b1;
    pulse_br(32'hFFFF_FFF8);
    decode_ready = 1'b0;
    wait_valid_rise(20);

    // Redirect while a request to 0x10 is outstanding; last branch wins
    lat = 4;
    expect_fetch(32'h10, 1'b0);
    pulse_br(32'hFFFF_FFE8);
    check("drop_req_addr", imem_addr, 32'h10);
    expect_fetch(32'h100, 1'b1);
    br_taken = 1'b1;
    b_offset = 32'h0000_01D8;
    @(negedge clk);
    b_offset = 32'h0000_00D8;
    @(negedge clk);
    br_taken = 1'b0;
    check("drop_valid_low", {31'b0, instr_valid}, 32'd0);
    wait_valid_rise(40);

    // Second instance: reset during a request, ack ignored, PC wrap
    rst2 = 1'b0;
    @(negedge clk);
    check("hi_first_req", {31'b0, req2}, 32'd1);
    check("hi_first_addr", addr2, 32'hFFFF_FFFC);
    rst2 = 1'b1;
    ack2 = 1'b1;
    rdata2 = 32'hDEAD_BEEF;
    @(negedge clk);
    ack2 = 1'b0;
    check("hi_rst_valid", {31'b0, valid2}, 32'd0);
    check("hi_rst_req", {31'b0, req2}, 32'd0);
    check("hi_rst_instr", instr2, 32'h0);
    check("hi_rst_ipc", ipc2, 32'h0);
    rst2 = 1'b0;
    @(negedge clk);
    check("hi_req_again", {31'b0, req2}, 32'd1);
    check("hi_addr_again", addr2, 32'hFFFF_FFFC);
    check("hi_no_valid", {31'b0, valid2}, 32'd0);
    ack2 = 1'b1;
    rdata2 = 32'h1234_5678;
    @(negedge clk);
    ack2 = 1'b0;
    check("hi_valid", {31'b0, valid2}, 32'd1);
    check("hi_ipc", ipc2, 32'hFFFF_FFFC);
    check("hi_instr", instr2, 32'h1234_5678);
    check("hi_link_wrap", link2, 32'h0);
    check("hi_hold_req", {31'b0, req2}, 32'd0);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    check("hi_wrap_req", {31'b0, req2}, 32'd1);
    check("hi_wrap_addr", addr2, 32'h0);
    check("hi_wrap_valid", {31'b0, valid2}, 32'd0);
    ack2 = 1'b1;
    rdata2 = 32'hCAFE_F00D;
    @(negedge clk);
    ack2 = 1'b0;
    check("hi_wrap_ipc", ipc2, 32'h0);
    check("hi_wrap_link", link2, 32'h4);
    check("hi_wrap_instr", instr2, 32'hCAFE_F00D);

    repeat (2) @(negedge clk);
    check("sb_addr_drain", 32'(q_addr.size()), 32'd0);
    check("sb_instr_drain", 32'(q_ipc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
